// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared 7-segment definitions: segment bit positions, the
//                16-entry hex glyph table and the scan FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

  // Segment bit positions inside the 7-bit abcdefg vector
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  // Hex glyphs, active-high abcdefg; entry k is the pattern for nibble k
  localparam logic [15:0][6:0] HEX_PAT = {
    7'b1000111,  // F
    7'b1001111,  // E
    7'b0111101,  // d
    7'b1001110,  // C
    7'b0011111,  // b
    7'b1110111,  // A
    7'b1111011,  // 9
    7'b1111111,  // 8
    7'b1110000,  // 7
    7'b1011111,  // 6
    7'b1011011,  // 5
    7'b0110011,  // 4
    7'b1111001,  // 3
    7'b1101101,  // 2
    7'b0110000,  // 1
    7'b1111110   // 0
  };

  // Scan FSM state encoding
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } scan_state_t;

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_to_hex.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_to_hex
//  Description : Combinational abcdefg -> {valid, nibble} lookup. Patterns
//                outside the hex glyph table report valid=0 and nibble 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic       o_valid,
  output logic [3:0] o_nibble
);

  // Search the glyph table; the table has no duplicates so at most one hits
  always_comb begin
    o_valid  = 1'b0;
    o_nibble = 4'h0;
    for (int k = 0; k < 16; k++) begin
      if (i_seg == HEX_PAT[k]) begin
        o_valid  = 1'b1;
        o_nibble = 4'(k);
      end
    end
  end

endmodule : seg7_to_hex
`default_nettype wire

// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_decoder
//  Description : Watches a multiplexed 7-segment bus, captures each digit once
//                its {enable, dp, segments} key has been stable long enough,
//                and publishes the full frame with error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NDIG        = 4,
  parameter int STABLE_CYC  = 4,
  parameter int SEG_ACT_LOW = 0,
  parameter int DIG_ACT_LOW = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        seg_in,
  input  logic              dp_in,
  input  logic [NDIG-1:0]   dig_en,
  output logic [4*NDIG-1:0] digits_out,
  output logic [NDIG-1:0]   dp_out,
  output logic              frame_valid,
  output logic              frame_err,
  output logic              pattern_err
);

  localparam int KW = NDIG + 8;
  localparam int CW = (STABLE_CYC < 2) ? 1 : $clog2(STABLE_CYC + 1);
  localparam logic [CW-1:0] c_CNT_LAST  = CW'(STABLE_CYC - 1);
  localparam bit            c_IMMEDIATE = (STABLE_CYC == 1);

  // Normalised, active-high view of the bus
  logic [6:0]      w_seg;
  logic            w_dp;
  logic [NDIG-1:0] w_dig;
  logic [KW-1:0]   w_key;
  logic            w_onehot;

  assign w_seg    = (SEG_ACT_LOW != 0) ? ~seg_in : seg_in;
  assign w_dp     = (SEG_ACT_LOW != 0) ? ~dp_in  : dp_in;
  assign w_dig    = (DIG_ACT_LOW != 0) ? ~dig_en : dig_en;
  assign w_key    = {w_dig, w_dp, w_seg};
  assign w_onehot = (w_dig != '0) && ((w_dig & (w_dig - NDIG'(1))) == '0);

  logic       w_dec_valid;
  logic [3:0] w_dec_nib;

  seg7_to_hex u_dec (
    .i_seg    (w_seg),
    .o_valid  (w_dec_valid),
    .o_nibble (w_dec_nib)
  );

  scan_state_t   r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [KW-1:0] r_key;
  logic          w_latch;
  logic          w_capture;

  // State register, stability counter and latched key
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_key   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_latch) r_key <= w_key;
    end
  end

  // Next-state logic: a new one-hot key restarts the count, blanking aborts
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (w_onehot) begin
          w_latch = 1'b1;
          if (c_IMMEDIATE) begin
            w_capture   = 1'b1;
            w_state_nxt = HELD;
          end else begin
            w_cnt_nxt   = CW'(1);
            w_state_nxt = SETTLE;
          end
        end
      end
      SETTLE, HELD: begin
        if (!w_onehot) begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else if (w_key != r_key) begin
          w_latch = 1'b1;
          if (c_IMMEDIATE) begin
            w_cnt_nxt   = '0;
            w_capture   = 1'b1;
            w_state_nxt = HELD;
          end else begin
            w_cnt_nxt   = CW'(1);
            w_state_nxt = SETTLE;
          end
        end else if (r_state == SETTLE) begin
          if (r_cnt == c_CNT_LAST) begin
            w_cnt_nxt   = '0;
            w_capture   = 1'b1;
            w_state_nxt = HELD;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  logic [4*NDIG-1:0] r_shadow, w_shadow_nxt;
  logic [NDIG-1:0]   r_sdp, w_sdp_nxt;
  logic [NDIG-1:0]   r_mask, w_mask_nxt;
  logic [NDIG-1:0]   r_errmask, w_err_nxt;
  logic              w_publish;

  // Merge the current capture into the shadow frame so publish sees it
  always_comb begin
    w_shadow_nxt = r_shadow;
    w_sdp_nxt    = r_sdp;
    w_mask_nxt   = r_mask;
    w_err_nxt    = r_errmask;
    if (w_capture) begin
      for (int i = 0; i < NDIG; i++) begin
        if (w_dig[i]) begin
          w_shadow_nxt[4*i +: 4] = w_dec_nib;
          w_sdp_nxt[i]           = w_dp;
          w_mask_nxt[i]          = 1'b1;
          w_err_nxt[i]           = ~w_dec_valid;
        end
      end
    end
  end

  assign w_publish = w_capture && (&w_mask_nxt);

  // Shadow frame bookkeeping and published outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow    <= '0;
      r_sdp       <= '0;
      r_mask      <= '0;
      r_errmask   <= '0;
      digits_out  <= '0;
      dp_out      <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      pattern_err <= 1'b0;
    end else begin
      r_shadow    <= w_shadow_nxt;
      r_sdp       <= w_sdp_nxt;
      frame_valid <= w_publish;
      pattern_err <= w_capture & ~w_dec_valid;
      if (w_publish) begin
        digits_out <= w_shadow_nxt;
        dp_out     <= w_sdp_nxt;
        frame_err  <= |w_err_nxt;
        r_mask     <= '0;
        r_errmask  <= '0;
      end else begin
        r_mask    <= w_mask_nxt;
        r_errmask <= w_err_nxt;
      end
    end
  end

endmodule : seg_scan_decoder
`default_nettype wire
